// File: rtl/sata_chan_pkg.sv
// Shared definitions for the SATA PHY channel model: ALIGN primitive,
// link state encoding and an ALIGN detector.
package sata_chan_pkg;

    localparam logic [31:0] ALIGN_DAT = 32'h7B4A_4ABC;
    localparam logic [3:0]  ALIGN_K   = 4'b0001;

    typedef enum logic [1:0] {
        DOWN  = 2'd0,
        TRAIN = 2'd1,
        UP    = 2'd2
    } link_state_t;

    function automatic logic is_align(input logic [31:0] dat, input logic [3:0] datchar);
        return (dat == ALIGN_DAT) && (datchar == ALIGN_K);
    endfunction

endpackage

// File: rtl/sata_chan_dly.sv
// One direction of the channel: circular delay line, ALIGN forcing outside UP,
// delivered-dword counter and optional error injection (SATA_CHAN_ERRINJ_EN).
module sata_chan_dly
    import sata_chan_pkg::*;
#(
    parameter int DW        = 32,
    parameter int KW        = 4,
    parameter int MAX_DELAY = 16,
    parameter int DLYW      = 5,
    parameter int CNTW      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            up_next,
    input  logic [DLYW-1:0] dly,
`ifdef SATA_CHAN_ERRINJ_EN
    input  logic            inj,
    input  logic [DW-1:0]   inj_mask,
`endif
    input  logic [DW-1:0]   tx_dat,
    input  logic [KW-1:0]   tx_datchar,
    output logic [DW-1:0]   rx_dat,
    output logic [KW-1:0]   rx_datchar,
    output logic [CNTW-1:0] cnt
);

    localparam int DEPTH = MAX_DELAY + 1;
    localparam int PW    = $clog2(DEPTH);

    logic [DW-1:0] mem_dat [DEPTH];
    logic [KW-1:0] mem_k   [DEPTH];
    logic [PW-1:0] wrptr;
    logic [PW-1:0] rdptr;
    logic [PW:0]   rd_sum;
    logic [DW-1:0] sel_dat;
    logic [KW-1:0] sel_k;
    logic [DW-1:0] nxt_dat;
    logic [KW-1:0] nxt_k;

    // A zero delay bypasses the buffer: the slot at wrptr is only written at this edge.
    always_comb begin
        rd_sum = {1'b0, wrptr} + (PW+1)'(DEPTH) - (PW+1)'(dly);
        if (rd_sum >= (PW+1)'(DEPTH)) begin
            rd_sum = rd_sum - (PW+1)'(DEPTH);
        end
        rdptr = rd_sum[PW-1:0];
        if (dly == '0) begin
            sel_dat = tx_dat;
            sel_k   = tx_datchar;
        end else begin
            sel_dat = mem_dat[rdptr];
            sel_k   = mem_k[rdptr];
        end
`ifdef SATA_CHAN_ERRINJ_EN
        if (inj) begin
            sel_dat = sel_dat ^ inj_mask;
        end
`endif
        if (up_next) begin
            nxt_dat = sel_dat;
            nxt_k   = sel_k;
        end else begin
            nxt_dat = DW'(ALIGN_DAT);
            nxt_k   = KW'(ALIGN_K);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrptr      <= '0;
            rx_dat     <= DW'(ALIGN_DAT);
            rx_datchar <= KW'(ALIGN_K);
            cnt        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_dat[i] <= DW'(ALIGN_DAT);
                mem_k[i]   <= KW'(ALIGN_K);
            end
        end else begin
            mem_dat[wrptr] <= tx_dat;
            mem_k[wrptr]   <= tx_datchar;
            wrptr          <= (wrptr == PW'(DEPTH - 1)) ? '0 : wrptr + PW'(1);
            rx_dat         <= nxt_dat;
            rx_datchar     <= nxt_k;
            if (up_next && !is_align(nxt_dat, nxt_k)) begin
                cnt <= cnt + CNTW'(1);
            end
        end
    end

endmodule

// File: rtl/sata_phy_chan_model.sv
// Full-duplex SATA channel model: link DOWN/TRAIN/UP sequencing, per-direction
// latency and traffic counters. Optional error injection via SATA_CHAN_ERRINJ_EN.
module sata_phy_chan_model
    import sata_chan_pkg::*;
#(
    parameter int DW        = 32,
    parameter int KW        = 4,
    parameter int MAX_DELAY = 16,
    parameter int DLYW      = 5,
    parameter int TRAIN_LEN = 64,
    parameter int CNTW      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_link_up,
    input  logic [DLYW-1:0] cfg_dly_h2d,
    input  logic [DLYW-1:0] cfg_dly_d2h,
    input  logic [DW-1:0]   h_tx_dat,
    input  logic [KW-1:0]   h_tx_datchar,
    output logic [DW-1:0]   h_rx_dat,
    output logic [KW-1:0]   h_rx_datchar,
    input  logic [DW-1:0]   d_tx_dat,
    input  logic [KW-1:0]   d_tx_datchar,
    output logic [DW-1:0]   d_rx_dat,
    output logic [KW-1:0]   d_rx_datchar,
    output logic            phyrdy_h,
    output logic            phyrdy_d,
    output logic [CNTW-1:0] cnt_h2d,
    output logic [CNTW-1:0] cnt_d2h,
`ifdef SATA_CHAN_ERRINJ_EN
    input  logic            inj_h2d,
    input  logic            inj_d2h,
    input  logic [DW-1:0]   inj_mask,
    output logic [CNTW-1:0] inj_cnt,
`endif
    output logic [1:0]      link_state
);

    localparam int TW = $clog2(TRAIN_LEN);

    link_state_t     state;
    link_state_t     state_next;
    logic [TW-1:0]   train_cnt;
    logic [TW-1:0]   train_next;
    logic [DLYW-1:0] dly_h2d;
    logic [DLYW-1:0] dly_d2h;
    logic            up_next;
    logic            up_now;

    function automatic logic [DLYW-1:0] clamp_dly(input logic [DLYW-1:0] v);
        return (v > DLYW'(MAX_DELAY)) ? DLYW'(MAX_DELAY) : v;
    endfunction

    // Dropping cfg_link_up wins over every other transition.
    always_comb begin
        state_next = state;
        train_next = train_cnt;
        case (state)
            DOWN: begin
                if (cfg_link_up) begin
                    state_next = TRAIN;
                    train_next = '0;
                end
            end
            TRAIN: begin
                if (!cfg_link_up) begin
                    state_next = DOWN;
                end else if (train_cnt == TW'(TRAIN_LEN - 1)) begin
                    state_next = UP;
                end else begin
                    train_next = train_cnt + TW'(1);
                end
            end
            UP: begin
                if (!cfg_link_up) begin
                    state_next = DOWN;
                end
            end
            default: state_next = DOWN;
        endcase
    end

    assign up_next    = (state_next == UP);
    assign up_now     = (state == UP);
    assign link_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= DOWN;
            train_cnt <= '0;
            dly_h2d   <= '0;
            dly_d2h   <= '0;
            phyrdy_h  <= 1'b0;
            phyrdy_d  <= 1'b0;
        end else begin
            state     <= state_next;
            train_cnt <= train_next;
            phyrdy_h  <= up_next;
            phyrdy_d  <= up_next;
            if (state == DOWN && cfg_link_up) begin
                dly_h2d <= clamp_dly(cfg_dly_h2d);
                dly_d2h <= clamp_dly(cfg_dly_d2h);
            end
        end
    end

`ifdef SATA_CHAN_ERRINJ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            inj_cnt <= '0;
        end else begin
            inj_cnt <= inj_cnt + CNTW'(inj_h2d & up_now) + CNTW'(inj_d2h & up_now);
        end
    end
`endif

    sata_chan_dly #(
        .DW(DW), .KW(KW), .MAX_DELAY(MAX_DELAY), .DLYW(DLYW), .CNTW(CNTW)
    ) u_h2d (
        .clk        (clk),
        .rst        (rst),
        .up_next    (up_next),
        .dly        (dly_h2d),
`ifdef SATA_CHAN_ERRINJ_EN
        .inj        (inj_h2d & up_now),
        .inj_mask   (inj_mask),
`endif
        .tx_dat     (h_tx_dat),
        .tx_datchar (h_tx_datchar),
        .rx_dat     (d_rx_dat),
        .rx_datchar (d_rx_datchar),
        .cnt        (cnt_h2d)
    );

    sata_chan_dly #(
        .DW(DW), .KW(KW), .MAX_DELAY(MAX_DELAY), .DLYW(DLYW), .CNTW(CNTW)
    ) u_d2h (
        .clk        (clk),
        .rst        (rst),
        .up_next    (up_next),
        .dly        (dly_d2h),
`ifdef SATA_CHAN_ERRINJ_EN
        .inj        (inj_d2h & up_now),
        .inj_mask   (inj_mask),
`endif
        .tx_dat     (d_tx_dat),
        .tx_datchar (d_tx_datchar),
        .rx_dat     (h_rx_dat),
        .rx_datchar (h_rx_datchar),
        .cnt        (cnt_d2h)
    );

endmodule
